// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction size and default reset vector.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    FETCH         = 2'd1,
    WAIT_REDIRECT = 2'd2,
    TRAP          = 2'd3
  } fetch_state_e;

  localparam int unsigned INSN_BYTES           = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch request sequencer with branch redirect handling.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            take_branch,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            trap,
  output logic [XLEN-1:0] trap_tval,
`endif
  output logic            flush
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSN_BYTES - 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic            flush_q, flush_d;
  logic            load;
  logic [XLEN-1:0] load_target;
`ifdef PC_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic [XLEN-1:0] tval_q, tval_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
      flush_q   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q    <= 1'b0;
      tval_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      flush_q   <= flush_d;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q    <= trap_d;
      tval_q    <= tval_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = pending_q;
    flush_d     = 1'b0;
    imem_req    = 1'b0;
    load        = 1'b0;
    load_target = pending_q;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d      = trap_q;
    tval_d      = tval_q;
`endif
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (!stall) begin
          if (take_branch) begin
            if (imem_ready) begin
              load        = 1'b1;
              load_target = branch_target;
            end else begin
              pending_d = branch_target;
              state_d   = WAIT_REDIRECT;
            end
          end else if (imem_ready) begin
            pc_d = pc_plus4;
          end
        end
      end
      WAIT_REDIRECT: begin
        imem_req = 1'b1;
        if (!stall) begin
          // A same-cycle redirect supersedes the parked one, even on the accepting edge.
          if (take_branch) begin
            pending_d   = branch_target;
            load_target = branch_target;
          end
          if (imem_ready) begin
            load    = 1'b1;
            state_d = FETCH;
          end
        end
      end
      TRAP: imem_req = 1'b0;
      default: state_d = IDLE;
    endcase

    if (load) begin
      flush_d = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
      if ((load_target & ~ALIGN_MASK) != '0) begin
        state_d = TRAP;
        trap_d  = 1'b1;
        tval_d  = load_target;
      end else begin
        pc_d = load_target;
      end
`else
      pc_d = load_target & ALIGN_MASK;
`endif
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + XLEN'(INSN_BYTES);
  assign flush     = flush_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign trap      = trap_q;
  assign trap_tval = tval_q;
`endif

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter: XLEN, 32, datapath and address width.
REQ-002 Parameter: RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: stall  in  1  hold PC and ignore take_branch this cycle.
REQ-006 Port: take_branch  in  1  branch/jump resolved taken (from branch decision logic).
REQ-007 Port: branch_target  in  XLEN  redirect address, valid with take_branch.
REQ-008 Port: imem_req  out  1  fetch request to instruction memory.
REQ-009 Port: imem_addr  out  XLEN  fetch address, equal to pc.
REQ-010 Port: imem_ready  in  1  memory accepts the current request this cycle.
REQ-011 Port: pc  out  XLEN  current program counter.
REQ-012 Port: pc_plus4  out  XLEN  pc + 4, combinational, modulo 2^XLEN.
REQ-013 Port: flush  out  1  one-cycle pulse: wrong-path instruction must be discarded.
REQ-014 Port: trap  out  1  misaligned-target trap (present only with macro).
REQ-015 Port: trap_tval  out  XLEN  offending target (present only with macro).

Function
REQ-016 States SHALL be: IDLE, FETCH, WAIT_REDIRECT, TRAP.
REQ-017 IDLE: imem_req=0; next state FETCH unconditionally.
REQ-018 FETCH: imem_req=1; imem_addr SHALL stay stable until imem_ready=1.
REQ-019 FETCH, stall=0, imem_ready=1, take_branch=0: pc <= pc+4 (wraps FFFF_FFFC -> 0000_0000).
REQ-020 FETCH, stall=0, take_branch=1, imem_ready=1: pc <= branch_target; flush=1 next cycle; redirect wins over sequential.
REQ-021 FETCH, stall=0, take_branch=1, imem_ready=0: latch target into pending register, go WAIT_REDIRECT, pc unchanged.
REQ-022 WAIT_REDIRECT: imem_req=1, imem_addr=pc; new take_branch (stall=0) overwrites pending target (latest wins).
REQ-023 WAIT_REDIRECT, imem_ready=1: pc <= pending (or incoming target if take_branch same cycle); flush=1 next cycle; go FETCH.
REQ-024 stall=1: pc, pending, state held; take_branch ignored; imem_req unchanged.
REQ-025 Redirect latency: pc shows target exactly one cycle after acceptance edge; flush high in that same cycle only.

Reset
REQ-026 On rst=1 at a clock edge: pc=RESET_VECTOR, state=IDLE, imem_req=0, flush=0, pending=0, trap=0, trap_tval=0.
REQ-027 rst SHALL override every other input, including mid-WAIT_REDIRECT and TRAP; pending redirect discarded.

Configuration
REQ-028 Macro PC_MISALIGN_TRAP_EN defined: target with [1:0]!=0 at acceptance -> state TRAP, trap=1, trap_tval=target, imem_req=0, flush=1 for one cycle, pc held; exit only by reset.
REQ-029 Macro undefined: trap/trap_tval ports absent, TRAP state unreachable; target[1:0] forced to 00 on load.

Structure
REQ-030 State encodings, INSN_BYTES=4 and default RESET_VECTOR SHALL live in src/defines.v.
REQ-031 Single module; no sub-module required.

Verification
REQ-032 Reset then imem_ready=1 constantly -> imem_req 0 one cycle, then imem_addr 0,4,8,C on successive cycles.
REQ-033 At pc=0x10, take_branch=1, target=0x100, imem_ready=1 -> next cycle pc=0x100, flush=1; following cycle flush=0, pc=0x104.
REQ-034 At pc=0x20, imem_ready=0, take_branch target=0x200 then target=0x300 next cycle, ready 2 cycles later -> imem_addr held 0x20, then pc=0x300, flush one cycle.
REQ-035 pc=0xFFFF_FFFC, ready=1 -> pc=0x0000_0000; stall=1 with take_branch=1 -> pc unchanged, no flush.
REQ-036 With PC_MISALIGN_TRAP_EN, target=0x102 -> trap=1, trap_tval=0x102, imem_req=0 until rst; without macro pc=0x100.
